imm_extender: RTL and testbench

Immediate extender for the single-cycle MIPS datapath. It widens the 16-bit instruction immediate to 32 bits by zero- or sign-extension under control of `extop`. It drives the ALU B-mux and the branch/LUI paths. A combinational output serves the single-cycle path, and a registered copy with valid flag serves pipelined or debug consumers.

---
 rtl/ext_pkg.sv | 17 +
 rtl/ext_core.sv | 30 +++
 rtl/imm_extender.sv | 65 ++++++
 tb/tb_imm_extender.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for immediate extension: extop codes, default widths, sext helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ext_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int IMM_W_DEF = 16;
  localparam int OUT_W_DEF = 32;

  // Sign-extend a default-width immediate to the default datapath width.
  function automatic logic [OUT_W_DEF-1:0] sext(input logic [IMM_W_DEF-1:0] imm);
    return {{(OUT_W_DEF-IMM_W_DEF){imm[IMM_W_DEF-1]}}, imm};
  endfunction

endpackage

// File: rtl/ext_core.sv
// Zero/sign extension of an IMM_W immediate to OUT_W bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs continuously.
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] imm,
  input  logic             extop,
  output logic [OUT_W-1:0] extout
);

  // The fill bit is the immediate MSB gated by the sign request, so an X on
  // extop shows up in the upper bits whenever it could change the result.
  generate
    if (OUT_W > IMM_W) begin : g_widen
      logic fill;
      assign fill   = imm[IMM_W-1] & (extop == EXT_SIGN);
      assign extout = {{(OUT_W-IMM_W){fill}}, imm};
    end else begin : g_same
      // Equal widths: nothing to extend, extop has no effect.
      logic unused_extop;
      assign unused_extop = extop;
      assign extout       = imm;
    end
  endgenerate

endmodule

// File: rtl/imm_extender.sv
// Immediate extender: combinational extout plus registered extout/lui/branch-offset copies.
// Latency: extout 0 cycles; registered outputs 1 cycle after an edge with en=1.
// Backpressure: none; en gates capture, valid_r stays set until reset.
module imm_extender
  import ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF   // must be at least IMM_W + 2
) (
  input  logic [IMM_W-1:0] imm,
  output logic [OUT_W-1:0] extout,
  input  logic             extop,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] extout_r,
  output logic [OUT_W-1:0] lui_r,
  output logic [OUT_W-1:0] boff_r,
  output logic             valid_r
);

  logic [OUT_W-3:0] boff_sext;
  logic [OUT_W-1:0] boff;
  logic [OUT_W-1:0] lui;

  // Datapath extension selected by the decoder.
  ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_ext_main (
    .imm    (imm),
    .extop  (extop),
    .extout (extout)
  );

  // Branch offset is always signed; only the bits that survive the
  // shift by two are produced.
  ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W-2)
  ) u_ext_boff (
    .imm    (imm),
    .extop  (EXT_SIGN),
    .extout (boff_sext)
  );

  assign boff = {boff_sext, 2'b00};
  assign lui  = {imm, {(OUT_W-IMM_W){1'b0}}};

  // Capture stage: reset wins over enable, otherwise hold unless en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      extout_r <= '0;
      lui_r    <= '0;
      boff_r   <= '0;
      valid_r  <= 1'b0;
    end else if (en) begin
      extout_r <= extout;
      lui_r    <= lui;
      boff_r   <= boff;
      valid_r  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// Directed self-checking bench for imm_extender with hand-computed expectations.
// Latency: checks extout after #1 and registered outputs on the falling edge.
// Backpressure: not applicable.
module tb_imm_extender;

  logic [15:0] imm;
  logic [31:0] extout;
  logic        extop;
  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] extout_r;
  logic [31:0] lui_r;
  logic [31:0] boff_r;
  logic        valid_r;

  int checks = 0;
  int errors = 0;

  imm_extender dut (
    .imm      (imm),
    .extout   (extout),
    .extop    (extop),
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .extout_r (extout_r),
    .lui_r    (lui_r),
    .boff_r   (boff_r),
    .valid_r  (valid_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational vector: drive, settle, compare extout.
  task automatic comb(input string tag, input logic [15:0] i, input logic op,
                      input logic [31:0] exp);
    imm   = i;
    extop = op;
    #1;
    check(tag, extout, exp);
  endtask

  task automatic regs(input string tag, input logic [31:0] e_ext, input logic [31:0] e_lui,
                      input logic [31:0] e_boff, input logic e_vld);
    check({tag, "_extout_r"}, extout_r, e_ext);
    check({tag, "_lui_r"},    lui_r,    e_lui);
    check({tag, "_boff_r"},   boff_r,   e_boff);
    check({tag, "_valid_r"},  {31'b0, valid_r}, {31'b0, e_vld});
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    imm   = 16'h0000;
    extop = 1'b0;

    // Combinational vectors (rst high must not matter).
    comb("z_1234",  16'h1234, 1'b0, 32'h0000_1234);
    comb("z_2345",  16'h2345, 1'b0, 32'h0000_2345);
    comb("s_1234",  16'h1234, 1'b1, 32'h0000_1234);
    comb("s_e001",  16'hE001, 1'b1, 32'hFFFF_E001);
    comb("z_e001",  16'hE001, 1'b0, 32'h0000_E001);
    comb("s_8000",  16'h8000, 1'b1, 32'hFFFF_8000);
    comb("z_8000",  16'h8000, 1'b0, 32'h0000_8000);
    comb("s_7fff",  16'h7FFF, 1'b1, 32'h0000_7FFF);
    comb("z_7fff",  16'h7FFF, 1'b0, 32'h0000_7FFF);
    comb("s_ffff",  16'hFFFF, 1'b1, 32'hFFFF_FFFF);
    comb("z_ffff",  16'hFFFF, 1'b0, 32'h0000_FFFF);

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    regs("rst", 32'h0, 32'h0, 32'h0, 1'b0);

    // First capture.
    rst   = 1'b0;
    en    = 1'b1;
    imm   = 16'hFFFF;
    extop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    regs("cap_ffff", 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFC, 1'b1);

    // Hold with en low while extout tracks the new immediate.
    en  = 1'b0;
    imm = 16'h0001;
    #1;
    check("hold_extout", extout, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    regs("hold", 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFC, 1'b1);

    // Zero-extend capture: branch offset stays signed.
    en    = 1'b1;
    imm   = 16'h8000;
    extop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    regs("cap_8000", 32'h0000_8000, 32'h8000_0000, 32'hFFFE_0000, 1'b1);

    // Reset together with enable clears registers; extout unaffected.
    rst   = 1'b1;
    en    = 1'b1;
    imm   = 16'h1234;
    extop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    regs("rst_en", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_extout", extout, 32'h0000_1234);

    // Capture resumes on the first edge with rst low and en high.
    rst   = 1'b0;
    imm   = 16'h7FFF;
    extop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    regs("cap_7fff", 32'h0000_7FFF, 32'h7FFF_0000, 32'h0001_FFFC, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
